// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: WIDTH-bit word in over valid/ready, shifted out MSB first,
// one bit per DIV clocks. Define PARITY_EN to append an even-parity bit period after the data bits.
module piso_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             s_out,
    output logic             ref_clk,
    output logic             busy,
    output logic             done
);

    localparam int DW = $clog2(DIV);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        even_parity = ^word;
    endfunction
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             s_out_q, s_out_d;
    logic             ref_q, ref_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             tick_s;
    logic [WIDTH-1:0] rot_s;

    assign tick_s = (div_q == DIV_LAST);
    // Rotate rather than shift so the captured word is never lost; its parity is rotation-invariant.
    assign rot_s  = (shreg_q << 1) | (shreg_q >> (WIDTH - 1));

    // Next-state and output decode for the transmit sequencer.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        s_out_d = s_out_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                div_d   = '0;
                if (din_valid && ready_q) begin
                    shreg_d = din;
                    state_d = ST_SHIFT;
                    s_out_d = din[WIDTH-1];
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (tick_s) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef PARITY_EN
                        state_d = ST_PAR;
                        s_out_d = even_parity(shreg_q);
`else
                        state_d = ST_IDLE;
                        s_out_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
`endif
                    end else begin
                        shreg_d = rot_s;
                        s_out_d = rot_s[WIDTH-1];
                        bit_d   = bit_q + CW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
`ifdef PARITY_EN
            ST_PAR: begin
                if (tick_s) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    s_out_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                s_out_d = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
        ref_d = (state_d != ST_IDLE) && (div_d < DIV_HALF);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            s_out_q <= 1'b0;
            ref_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            s_out_q <= s_out_d;
            ref_q   <= ref_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign din_ready = ready_q;
    assign s_out     = s_out_q;
    assign ref_clk   = ref_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx (WIDTH=4, DIV=4): per-cycle comparison against a frame-timeline model,
// directed frames with literal expectations, then randomized traffic with occasional resets.
module tb_piso_tx;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
`ifdef PARITY_EN
    localparam int NB = WIDTH + 1;
    localparam logic [NB-1:0] LIT_F1 = 5'b10111;
    localparam logic [NB-1:0] LIT_F2 = 5'b01100;
`else
    localparam int NB = WIDTH;
    localparam logic [NB-1:0] LIT_F1 = 4'b1011;
    localparam logic [NB-1:0] LIT_F2 = 4'b0110;
`endif
    localparam int FLEN = NB * DIV;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready, s_out, ref_clk, busy, done;

    int tests = 0;
    int fails = 0;

    piso_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .s_out     (s_out),
        .ref_clk   (ref_clk),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Model: 0 = in/after reset (no clock yet), 1 = idle, 2 = frame in flight, t cycles since accept.
    int               m_mode = 0;
    int               m_t = 0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_word = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0;
            m_done = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_done = 1'b0;
        end else if (m_mode == 1) begin
            m_done = 1'b0;
            if (din_valid === 1'b1) begin
                m_mode = 2;
                m_t    = 0;
                m_word = din;
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == FLEN) begin
                m_mode = 1;
                m_done = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic step();
        logic e_s, e_r, e_b, e_d, e_rdy;
        int   k;
        @(negedge clk);
        e_s = 1'b0; e_r = 1'b0; e_b = 1'b0; e_d = 1'b0; e_rdy = 1'b0;
        if (m_mode == 1) begin
            e_rdy = 1'b1;
            e_d   = m_done;
        end else if (m_mode == 2) begin
            k   = m_t / DIV;
            e_s = (k < WIDTH) ? m_word[WIDTH-1-k] : ^m_word;
            e_r = (m_t % DIV) < (DIV / 2);
            e_b = 1'b1;
        end
        chk("s_out",     {31'd0, s_out},     {31'd0, e_s});
        chk("ref_clk",   {31'd0, ref_clk},   {31'd0, e_r});
        chk("busy",      {31'd0, busy},      {31'd0, e_b});
        chk("done",      {31'd0, done},      {31'd0, e_d});
        chk("din_ready", {31'd0, din_ready}, {31'd0, e_rdy});
    endtask

    // Follow one frame whose accept edge has just been set up; step i=1 is the first cycle after accept.
    task automatic capture(input logic hold, input logic [WIDTH-1:0] nxt,
                           output logic [NB-1:0] bits, output int ref_hi,
                           output int busy_n, output logic done_v, output logic gap_s);
        bits = '0; ref_hi = 0; busy_n = 0;
        for (int i = 1; i <= FLEN; i++) begin
            step();
            if (i == 1) begin
                din = nxt;
                if (!hold) din_valid = 1'b0;
            end
            if (!hold && i == 5) begin
                din       = 4'hF;
                din_valid = 1'b1;
            end
            if (!hold && i == 6) din_valid = 1'b0;
            if (i % DIV == 2) bits = {bits[NB-2:0], s_out};
            ref_hi += int'(ref_clk);
            busy_n += int'(busy);
        end
        step();
        done_v = done;
        gap_s  = s_out;
    endtask

    logic [NB-1:0] bits;
    int            ref_hi, busy_n;
    logic          done_v, gap_s;

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", {31'd0, din_ready}, 32'd1);
        chk("idle_s_out",        {31'd0, s_out},     32'd0);
        repeat (2) step();

        // Single frame 1011 with a mid-frame din/valid pulse that must be ignored.
        din = 4'b1011; din_valid = 1'b1;
        capture(1'b0, 4'h0, bits, ref_hi, busy_n, done_v, gap_s);
        chk("frame1_bits",  {{(32-NB){1'b0}}, bits}, {{(32-NB){1'b0}}, LIT_F1});
        chk("frame1_ref",   ref_hi, FLEN / 2);
        chk("frame1_busy",  busy_n, FLEN);
        chk("frame1_done",  {31'd0, done_v}, 32'd1);
        chk("frame1_s_end", {31'd0, gap_s},  32'd0);
        repeat (3) step();

        // Back-to-back: valid held, second word accepted in the done cycle.
        din = 4'b1011; din_valid = 1'b1;
        capture(1'b1, 4'b0110, bits, ref_hi, busy_n, done_v, gap_s);
        chk("b2b_f1_bits", {{(32-NB){1'b0}}, bits}, {{(32-NB){1'b0}}, LIT_F1});
        chk("b2b_gap",     {31'd0, gap_s}, 32'd0);
        capture(1'b0, 4'h0, bits, ref_hi, busy_n, done_v, gap_s);
        chk("b2b_f2_bits", {{(32-NB){1'b0}}, bits}, {{(32-NB){1'b0}}, LIT_F2});
        chk("b2b_f2_done", {31'd0, done_v}, 32'd1);
        repeat (2) step();

        // Reset in the sixth cycle of a frame.
        din = 4'b1011; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (6) step();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_s_out",   {31'd0, s_out},     32'd0);
        chk("rst_busy",    {31'd0, busy},      32'd0);
        chk("rst_ref_clk", {31'd0, ref_clk},   32'd0);
        chk("rst_ready",   {31'd0, din_ready}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (FLEN + 4) begin
            step();
            chk("no_done_after_abort", {31'd0, done}, 32'd0);
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            step();
            din       = WIDTH'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 399) != 0);
        end
        rst_n = 1'b1;
        repeat (FLEN + 2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
